// File: rtl/scoreboard_hazard_unit.sv
// Scoreboarded hazard controller: load scoreboard, stall/flush generation, redirect FSM and
// EX forwarding selects. Define HAZARD_PERF_EN to add saturating stall/flush perf counters.
module scoreboard_hazard_unit #(
  parameter int unsigned NREGS     = 32,
  parameter int unsigned MAX_OUTST = 4,
  parameter int unsigned REDIR_PEN = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     d_valid_i,
  input  logic [$clog2(NREGS)-1:0] d_rs1_i,
  input  logic [$clog2(NREGS)-1:0] d_rs2_i,
  input  logic                     d_rs1_used_i,
  input  logic                     d_rs2_used_i,
  input  logic [$clog2(NREGS)-1:0] d_rd_i,
  input  logic                     d_memren_i,
  input  logic [$clog2(NREGS)-1:0] e_rs1_i,
  input  logic [$clog2(NREGS)-1:0] e_rs2_i,
  input  logic                     e_redirect_i,
  input  logic [$clog2(NREGS)-1:0] m_rd_i,
  input  logic                     m_regwren_i,
  input  logic [$clog2(NREGS)-1:0] w_rd_i,
  input  logic                     w_regwren_i,
  input  logic                     ld_resp_valid_i,
  input  logic [$clog2(NREGS)-1:0] ld_resp_rd_i,
  output logic                     stall_if_o,
  output logic                     ifid_wren_o,
  output logic                     ifid_flush_o,
  output logic                     idex_flush_o,
  output logic [1:0]               rs1_sel_o,
  output logic [1:0]               rs2_sel_o,
  output logic                     d_issue_o
`ifdef HAZARD_PERF_EN
  ,
  output logic [31:0]              perf_stall_cnt_o,
  output logic [31:0]              perf_flush_cnt_o
`endif
);

  localparam int unsigned AW = $clog2(NREGS);
  localparam int unsigned OW = $clog2(MAX_OUTST + 1);
  localparam int unsigned CW = (REDIR_PEN > 1) ? $clog2(REDIR_PEN) : 1;
  localparam logic [OW-1:0] MaxOutst  = OW'(MAX_OUTST);
  localparam logic [CW-1:0] CntReload = CW'(REDIR_PEN - 1);
  localparam bit            MultiCyc  = (REDIR_PEN > 1);

  typedef enum logic {StRun, StFlush} state_e;

  state_e            state_q;
  logic [CW-1:0]     cnt_q;
  logic [NREGS-1:0]  pending_q, pending_d;
  logic [OW-1:0]     outst_q, outst_d;
  logic [NREGS-1:0]  ready;
  logic              run, src_haz, waw_haz, full_haz, stall, issue, set_pend, dec_outst;
  logic [1:0]        rs1_sel, rs2_sel;

  // A returning load is written this cycle and the regfile is write-before-read.
  always_comb begin
    ready = ~pending_q;
    for (int unsigned r = 0; r < NREGS; r++) begin
      if (ld_resp_valid_i && (ld_resp_rd_i == AW'(r))) ready[r] = 1'b1;
    end
    ready[0] = 1'b1;
  end

  always_comb begin
    run       = (state_q == StRun);
    src_haz   = d_valid_i & ((d_rs1_used_i & ~ready[d_rs1_i]) |
                             (d_rs2_used_i & ~ready[d_rs2_i]));
    waw_haz   = d_valid_i & d_memren_i & (d_rd_i != '0) & ~ready[d_rd_i];
    full_haz  = d_valid_i & d_memren_i & (outst_q == MaxOutst) & ~ld_resp_valid_i;
    stall     = (src_haz | waw_haz | full_haz) & run & ~e_redirect_i;
    issue     = d_valid_i & ~stall & ~e_redirect_i & run;
    set_pend  = issue & d_memren_i & (d_rd_i != '0);
    dec_outst = ld_resp_valid_i & (outst_q != '0);
  end

  // Clear before set so a same-register set wins.
  always_comb begin
    pending_d = pending_q;
    if (ld_resp_valid_i) pending_d[ld_resp_rd_i] = 1'b0;
    if (set_pend) pending_d[d_rd_i] = 1'b1;
    unique case ({set_pend, dec_outst})
      2'b10:   outst_d = outst_q + 1'b1;
      2'b01:   outst_d = outst_q - 1'b1;
      default: outst_d = outst_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      outst_q   <= '0;
    end else begin
      pending_q <= pending_d;
      outst_q   <= outst_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (e_redirect_i && MultiCyc) begin
            state_q <= StFlush;
            cnt_q   <= CntReload;
          end
        end
        StFlush: begin
          if (e_redirect_i) begin
            cnt_q <= CntReload;
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) state_q <= StRun;
          end
        end
        default: state_q <= StRun;
      endcase
    end
  end

  function automatic logic [1:0] fwd_sel(input logic [AW-1:0] rs, input logic [AW-1:0] mrd,
                                         input logic mwe, input logic [AW-1:0] wrd,
                                         input logic wwe);
    if (mwe && (mrd != '0) && (mrd == rs)) return 2'b01;
    if (wwe && (wrd != '0) && (wrd == rs)) return 2'b10;
    return 2'b00;
  endfunction

  always_comb begin
    rs1_sel = fwd_sel(e_rs1_i, m_rd_i, m_regwren_i, w_rd_i, w_regwren_i);
    rs2_sel = fwd_sel(e_rs2_i, m_rd_i, m_regwren_i, w_rd_i, w_regwren_i);
  end

  // Outputs are held at their reset values while rst_ni is low.
  always_comb begin
    stall_if_o   = rst_ni & stall;
    ifid_wren_o  = ~rst_ni | ~stall;
    ifid_flush_o = rst_ni & (e_redirect_i | ~run);
    idex_flush_o = rst_ni & (stall | e_redirect_i | ~run);
    d_issue_o    = rst_ni & issue;
    rs1_sel_o    = rst_ni ? rs1_sel : 2'b00;
    rs2_sel_o    = rst_ni ? rs2_sel : 2'b00;
  end

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + 1'b1;
      if (ifid_flush_o && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + 1'b1;
    end
  end

  assign perf_stall_cnt_o = perf_stall_q;
  assign perf_flush_cnt_o = perf_flush_q;
`endif

endmodule
